// File: rtl/proc_pkg.sv
// Shared definitions for the data memory responder: bus width, default
// geometry and timing, the responder FSM state type and the captured
// request record.
package proc_pkg;

  localparam int DATA_W       = 32;
  localparam int DM_DEPTH_DEF = 256;
  localparam int DM_WAIT_DEF  = 1;

  typedef enum logic [1:0] {
    DM_IDLE = 2'd0,
    DM_WAIT = 2'd1,
    DM_RESP = 2'd2
  } dm_state_t;

  // Request fields that do not depend on the array depth. The word index is
  // held separately because its width follows DEPTH.
  typedef struct packed {
    logic              we;
    logic              rej;
    logic [DATA_W-1:0] wdata;
  } dm_req_t;

endpackage

// File: rtl/data_mem_responder_if.sv
// Control-unit <-> data memory bus. The control unit is the master; the
// responder is the slave.
interface data_mem_responder_if;
  import proc_pkg::*;

  logic              enableDM;
  logic              WriteDM;
  logic [31:0]       addr;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] rdata;
  logic              ready;
  logic              stall;
  logic              err;

  modport master (
    output enableDM, WriteDM, addr, wdata,
    input  rdata, ready, stall, err
  );

  modport slave (
    input  enableDM, WriteDM, addr, wdata,
    output rdata, ready, stall, err
  );
endinterface

// File: rtl/data_mem_responder_dm_array.sv
// Word storage for the data memory responder: one synchronous write port,
// one combinational read port, contents cleared by reset.
module dm_array
  import proc_pkg::*;
#(
  parameter int DEPTH = DM_DEPTH_DEF
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [DATA_W-1:0]        wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [DATA_W-1:0]        rdata
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  // Storage update: clear everything on reset, otherwise one word per write.
  // NOTE: the array must read back zero after reset, so it is built from
  // resettable flops rather than a RAM macro, which cannot clear in one step.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/data_mem_responder.sv
// Data memory responder: accepts one load/store from the control unit,
// inserts WAIT_CYCLES wait states, then pulses ready (and err on a rejected
// access). stall holds the control step counter while an access is open.
// Optional macro DM_ALIGN_CHECK_EN: reject accesses with addr[1:0] != 0.
module data_mem_responder
  import proc_pkg::*;
#(
  parameter int DEPTH       = DM_DEPTH_DEF,
  parameter int WAIT_CYCLES = DM_WAIT_DEF
) (
  input  logic                clk,
  input  logic                reset,
  data_mem_responder_if.slave bus
);

  localparam int         AW        = $clog2(DEPTH);
  localparam bit         NO_WAIT   = (WAIT_CYCLES == 0);
  localparam logic [3:0] WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  dm_state_t         state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  dm_req_t           req_q, req_d;
  logic [AW-1:0]     idx_q, idx_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              ready_q, ready_d;
  logic              err_q, err_d;

  dm_req_t           live_req, cur_req;
  logic [AW-1:0]     live_idx, cur_idx;
  logic              enter_resp;
  logic              arr_we;
  logic [DATA_W-1:0] arr_rdata;

  // Classify the request currently on the bus: range and optional alignment.
  always_comb begin
    live_req.we    = bus.WriteDM;
    live_req.wdata = bus.wdata;
    live_req.rej   = |bus.addr[31:AW+2];
`ifdef DM_ALIGN_CHECK_EN
    live_req.rej   = live_req.rej | (|bus.addr[1:0]);
`endif
    live_idx       = bus.addr[AW+1:2];
  end

`ifndef DM_ALIGN_CHECK_EN
  // Byte offset plays no part when alignment is not checked.
  logic unused_addr_lsb;
  assign unused_addr_lsb = ^bus.addr[1:0];
`endif

  // With no wait states the access completes on the accepting edge, so the
  // live bus fields stand in for the not-yet-captured ones.
  always_comb begin
    cur_req = (state_q == DM_IDLE) ? live_req : req_q;
    cur_idx = (state_q == DM_IDLE) ? live_idx : idx_q;
  end

  // Access sequencing: accept in IDLE, count wait states, respond once.
  // NOTE: every output of this block gets a default first so no path leaves
  // a variable unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    req_d      = req_q;
    idx_d      = idx_q;
    enter_resp = 1'b0;
    case (state_q)
      DM_IDLE: begin
        if (bus.enableDM) begin
          req_d = live_req;
          idx_d = live_idx;
          if (NO_WAIT) begin
            state_d    = DM_RESP;
            enter_resp = 1'b1;
          end else begin
            state_d = DM_WAIT;
            cnt_d   = WAIT_LOAD;
          end
        end
      end
      DM_WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d    = DM_RESP;
          enter_resp = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      DM_RESP: state_d = DM_IDLE;
      default: state_d = DM_IDLE;
    endcase
  end

  // Completion side effects, all taken on the edge that enters RESP.
  always_comb begin
    ready_d = enter_resp;
    err_d   = enter_resp & cur_req.rej;
    arr_we  = enter_resp & cur_req.we & ~cur_req.rej;
    rdata_d = rdata_q;
    if (enter_resp && !cur_req.we) begin
      rdata_d = cur_req.rej ? '0 : arr_rdata;
    end
  end

  // State registers.
  // NOTE: non-blocking assignments let every flop sample the pre-edge values,
  // independent of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= DM_IDLE;
      cnt_q   <= 4'd0;
      req_q   <= '0;
      idx_q   <= '0;
      rdata_q <= '0;
      ready_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
      idx_q   <= idx_d;
      rdata_q <= rdata_d;
      ready_q <= ready_d;
      err_q   <= err_d;
    end
  end

  dm_array #(
    .DEPTH (DEPTH)
  ) u_dm_array (
    .clk   (clk),
    .reset (reset),
    .we    (arr_we),
    .waddr (cur_idx),
    .wdata (cur_req.wdata),
    .raddr (cur_idx),
    .rdata (arr_rdata)
  );

  assign bus.rdata = rdata_q;
  assign bus.ready = ready_q;
  assign bus.err   = err_q;
  assign bus.stall = ((state_q == DM_IDLE) && bus.enableDM) || (state_q == DM_WAIT);

endmodule
